// File: rtl/phased_tx_burst_scheduler.sv
// Phased-array transmit sequencer: latch angle, compute per-channel carrier offsets, burst, listen, repeat.
// tx_out is registered (one clock behind the burst counter); no backpressure, the frame runs free once started.
module phased_tx_burst_scheduler #(
   parameter int NUM_TX       = 8,
   parameter int WAVE_PERIOD  = 2500,
   parameter int WAVE_HIGH    = 1250,
   parameter int DELAY_PER_TX = 2623,
   parameter int SIN_WIDTH    = 17,
   parameter int BURST_CYCLES = 524288,
   parameter int FRAME_CYCLES = 16777216
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic                 auto_in,
   input  logic [SIN_WIDTH-1:0] sin_theta_in,
   input  logic                 sign_in,
   input  logic [NUM_TX-1:0]    ch_mask_in,
   output logic [NUM_TX-1:0]    tx_out,
   output logic                 busy_out,
   output logic                 burst_out,
   output logic                 listen_out,
   output logic                 done_out
);

   localparam int OFF_W  = $clog2(WAVE_PERIOD);
   localparam int IDX_W  = $clog2(NUM_TX);
   localparam int CNT_W  = $clog2(FRAME_CYCLES);
   localparam int CMP_W  = (CNT_W > OFF_W) ? CNT_W : OFF_W;
   localparam int PROD_W = $clog2(DELAY_PER_TX + 1) + $clog2(NUM_TX) + SIN_WIDTH + 1;

   localparam logic [SIN_WIDTH-1:0] SIN_ONE    = SIN_WIDTH'(1) << (SIN_WIDTH - 1);
   localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_TX - 1);
   localparam logic [CNT_W-1:0]     BURST_LAST = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0]     FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [OFF_W-1:0]     PH_LAST    = OFF_W'(WAVE_PERIOD - 1);
   localparam logic [OFF_W-1:0]     PH_HIGH    = OFF_W'(WAVE_HIGH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_COMPUTE,
      S_BURST,
      S_LISTEN
   } state_t;

   logic [1:0]           r_rst_sync;
   logic                 w_rst;
   state_t               r_state;
   state_t               w_next;
   logic                 w_done;

   logic [SIN_WIDTH-1:0] r_sin;
   logic                 r_sign;
   logic [NUM_TX-1:0]    r_mask;
   logic [SIN_WIDTH-1:0] w_sin_clamp;

   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_k;
   logic [PROD_W-1:0]    w_prod;
   logic [PROD_W-1:0]    w_shift;
   logic [OFF_W-1:0]     w_off;
   logic [OFF_W-1:0]     r_off [NUM_TX];

   logic [CNT_W-1:0]     r_cnt;
   logic [NUM_TX-1:0]    r_run;
   logic [OFF_W-1:0]     r_ph [NUM_TX];
   logic [NUM_TX-1:0]    r_tx;
   logic [NUM_TX-1:0]    w_hit;
   logic [NUM_TX-1:0]    w_run;
   logic [NUM_TX-1:0]    w_tx;
   logic [OFF_W-1:0]     w_ph [NUM_TX];

   // Reset asserts immediately but releases two clocks later, aligned to clk_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_rst_sync <= 2'b11;
      else        r_rst_sync <= {r_rst_sync[0], 1'b0};
   end
   assign w_rst = r_rst_sync[1];

   always_ff @(posedge clk_in or posedge w_rst) begin
      if (w_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         S_IDLE:    if (start_in) w_next = S_LATCH;
         S_LATCH:   w_next = S_COMPUTE;
         S_COMPUTE: if (r_idx == LAST_IDX) w_next = S_BURST;
         S_BURST:   if (r_cnt == BURST_LAST) w_next = S_LISTEN;
         S_LISTEN: begin
            if (r_cnt == FRAME_LAST) begin
               w_done = 1'b1;
               w_next = auto_in ? S_LATCH : S_IDLE;
            end
         end
         default:   w_next = S_IDLE;
      endcase
   end

   assign w_sin_clamp = (sin_theta_in > SIN_ONE) ? SIN_ONE : sin_theta_in;

   always_ff @(posedge clk_in or posedge w_rst) begin
      if (w_rst) begin
         r_sin  <= '0;
         r_sign <= 1'b0;
         r_mask <= '0;
      end else if (r_state == S_LATCH) begin
         r_sin  <= w_sin_clamp;
         r_sign <= sign_in;
         r_mask <= ch_mask_in;
      end
   end

   // One channel offset per COMPUTE cycle; the modulo is by a constant period.
   assign w_k     = r_sign ? (LAST_IDX - r_idx) : r_idx;
   assign w_prod  = PROD_W'(DELAY_PER_TX) * PROD_W'(w_k) * PROD_W'(r_sin);
   assign w_shift = w_prod >> (SIN_WIDTH - 1);
   assign w_off   = OFF_W'(w_shift % PROD_W'(WAVE_PERIOD));

   always_ff @(posedge clk_in or posedge w_rst) begin
      if (w_rst) begin
         r_idx <= '0;
         for (int i = 0; i < NUM_TX; i++) r_off[i] <= '0;
      end else if (r_state == S_COMPUTE) begin
         r_off[r_idx] <= w_off;
         r_idx        <= r_idx + IDX_W'(1);
      end else begin
         r_idx <= '0;
      end
   end

   always_ff @(posedge clk_in or posedge w_rst) begin
      if (w_rst)                                          r_cnt <= '0;
      else if (r_state == S_BURST || r_state == S_LISTEN) r_cnt <= r_cnt + CNT_W'(1);
      else                                                r_cnt <= '0;
   end

   // A channel starts its wrapping phase counter when the burst count reaches its offset.
   always_comb begin
      w_hit = '0;
      w_run = '0;
      w_tx  = '0;
      w_ph  = '{default: '0};
      for (int i = 0; i < NUM_TX; i++) begin
         w_hit[i] = (CMP_W'(r_cnt) == CMP_W'(r_off[i]));
         w_run[i] = r_run[i] | w_hit[i];
         w_ph[i]  = r_run[i] ? r_ph[i] : '0;
         w_tx[i]  = r_mask[i] & w_run[i] & (w_ph[i] < PH_HIGH);
      end
   end

   always_ff @(posedge clk_in or posedge w_rst) begin
      if (w_rst) begin
         r_run <= '0;
         r_tx  <= '0;
         for (int i = 0; i < NUM_TX; i++) r_ph[i] <= '0;
      end else if (r_state == S_BURST) begin
         r_tx <= w_tx;
         for (int i = 0; i < NUM_TX; i++) begin
            if (w_run[i]) begin
               r_run[i] <= 1'b1;
               r_ph[i]  <= (w_ph[i] == PH_LAST) ? '0 : w_ph[i] + OFF_W'(1);
            end
         end
      end else begin
         r_run <= '0;
         r_tx  <= '0;
      end
   end

   assign tx_out     = r_tx;
   assign busy_out   = (r_state != S_IDLE);
   assign burst_out  = (r_state == S_BURST);
   assign listen_out = (r_state == S_LISTEN);
   assign done_out   = w_done;

endmodule

// File: tb/tb_phased_tx_burst_scheduler.sv
// Directed bench: two instances (DELAY_PER_TX 5 and 9) share stimulus; every frame cycle is checked.
module tb_phased_tx_burst_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, auto_r, sign;
   logic [4:0] sin;
   logic [3:0] mask;
   logic [3:0] tx1, tx2;
   logic       busy1, burst1, listen1, done1;
   logic       busy2, burst2, listen2, done2;
   int         n_assert = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   phased_tx_burst_scheduler #(
      .NUM_TX(4), .WAVE_PERIOD(20), .WAVE_HIGH(10), .DELAY_PER_TX(5),
      .SIN_WIDTH(5), .BURST_CYCLES(60), .FRAME_CYCLES(100)
   ) u_dut1 (
      .clk_in(clk), .rst_in(rst), .start_in(start), .auto_in(auto_r),
      .sin_theta_in(sin), .sign_in(sign), .ch_mask_in(mask),
      .tx_out(tx1), .busy_out(busy1), .burst_out(burst1),
      .listen_out(listen1), .done_out(done1)
   );

   phased_tx_burst_scheduler #(
      .NUM_TX(4), .WAVE_PERIOD(20), .WAVE_HIGH(10), .DELAY_PER_TX(9),
      .SIN_WIDTH(5), .BURST_CYCLES(60), .FRAME_CYCLES(100)
   ) u_dut2 (
      .clk_in(clk), .rst_in(rst), .start_in(start), .auto_in(auto_r),
      .sin_theta_in(sin), .sign_in(sign), .ch_mask_in(mask),
      .tx_out(tx2), .busy_out(busy2), .burst_out(burst2),
      .listen_out(listen2), .done_out(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected drive for burst time t; offs holds one offset per byte, channel 0 in the low byte.
   function automatic logic [3:0] exp_tx(input int t, input logic [31:0] offs, input logic [3:0] m);
      logic [3:0] r;
      int off;
      r = '0;
      if (t >= 0 && t < 60) begin
         for (int i = 0; i < 4; i++) begin
            off = int'(offs[i*8 +: 8]);
            if (m[i] && t >= off && ((t - off) % 20) < 10) r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic run_frame(input string tag, input bit do_start, input bit hold_start,
                            input int exp_lat, input logic [31:0] o1, input logic [31:0] o2,
                            input logic [3:0] m, input logic [4:0] nsin, input bit nauto,
                            input bit busy_after);
      int n;
      if (do_start) start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!hold_start) start = 1'b0;
      end while (!burst1 && n < 30);
      chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
      for (int c = 0; c < 100; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("%s:burst@%0d", tag, c), 32'(burst1), 32'(c < 60));
         chk($sformatf("%s:listen@%0d", tag, c), 32'(listen1), 32'(c >= 60));
         chk($sformatf("%s:done@%0d", tag, c), 32'(done1), 32'(c == 99));
         chk($sformatf("%s:busy@%0d", tag, c), 32'(busy1), 32'(1));
         chk($sformatf("%s:tx1@%0d", tag, c), 32'(tx1), 32'(exp_tx(c - 1, o1, m)));
         chk($sformatf("%s:tx2@%0d", tag, c), 32'(tx2), 32'(exp_tx(c - 1, o2, m)));
         if (c == 30) begin
            sin    = nsin;
            auto_r = nauto;
         end
      end
      @(negedge clk);
      chk({tag, ":busy_after"}, 32'(busy1), 32'(busy_after));
      chk({tag, ":tx_after"}, 32'({tx1, tx2}), 32'(0));
      chk({tag, ":done_after"}, 32'(done1), 32'(0));
      if (hold_start) start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; auto_r = 1'b0; sin = '0; sign = 1'b0; mask = '0;
      repeat (3) @(negedge clk);
      chk("reset:tx", 32'(tx1), 32'(0));
      chk("reset:busy", 32'(busy1), 32'(0));
      chk("reset:burst", 32'(burst1), 32'(0));
      chk("reset:listen", 32'(listen1), 32'(0));
      chk("reset:done", 32'(done1), 32'(0));
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle:busy", 32'(busy1), 32'(0));

      // sin = 0.5: offsets 0,2,5,7 (D=5) and 0,4,9,13 (D=9)
      sin = 5'd8; sign = 1'b0; mask = 4'hF;
      run_frame("s8pos", 1, 0, 6, 32'h07050200, 32'h0d090400, 4'hF, 5'd8, 0, 0);

      sign = 1'b1;
      run_frame("s8neg", 1, 0, 6, 32'h00020507, 32'h0004090d, 4'hF, 5'd8, 0, 0);

      // sin = 1.0: D=9 raw 0,9,18,27 wraps to 0,9,18,7; 31 clamps to the same
      sign = 1'b0; sin = 5'd16;
      run_frame("s16", 1, 0, 6, 32'h0f0a0500, 32'h07120900, 4'hF, 5'd16, 0, 0);
      sin = 5'd31;
      run_frame("s31clamp", 1, 0, 6, 32'h0f0a0500, 32'h07120900, 4'hF, 5'd31, 0, 0);

      // Auto-repeat with partial mask; new sin applied mid-frame takes effect next frame
      sin = 5'd8; mask = 4'h5; auto_r = 1'b1;
      run_frame("auto1", 1, 0, 6, 32'h07050200, 32'h0d090400, 4'h5, 5'd16, 1, 1);
      run_frame("auto2", 0, 0, 5, 32'h0f0a0500, 32'h07120900, 4'h5, 5'd16, 0, 0);

      // start held high through the frame: one frame only
      sin = 5'd8; mask = 4'hF; auto_r = 1'b0;
      run_frame("hold", 1, 1, 6, 32'h07050200, 32'h0d090400, 4'hF, 5'd8, 0, 0);
      @(negedge clk);
      chk("hold:idle", 32'(busy1), 32'(0));

      // Reset in the middle of a burst
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      chk("rstmid:burst", 32'(burst1), 32'(1));
      chk("rstmid:tx_pre", 32'(tx1), 32'(4'h3));
      rst = 1'b1;
      #1;
      chk("rstmid:tx", 32'(tx1), 32'(0));
      chk("rstmid:busy", 32'(busy1), 32'(0));
      chk("rstmid:burst_off", 32'(burst1), 32'(0));
      chk("rstmid:done", 32'(done1), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstmid:idle", 32'(busy1), 32'(0));
      run_frame("postrst", 1, 0, 6, 32'h07050200, 32'h0d090400, 4'hF, 5'd8, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
